// File: rtl/regfile_pkg.sv
// Shared register-file constants and the requester-side writeback bundle.
package regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  // One writeback source as seen at the integration level.
  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request bus: NUM_REQ packed requesters plus the one-hot ready.
// master = writeback sources, slave = the arbiter.
interface regfile_wb_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;

  modport master (
    output req_valid,
    output req_addr,
    output req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    input  req_data,
    output req_ready
  );

endinterface

// File: rtl/regfile_wb_arbiter_rr_pick.sv
// rr_pick: combinational round-robin pick. Searches the request vector
// starting just above ptr and wrapping, returning a one-hot grant and its
// index. Equivalent to rotate / priority-encode / un-rotate.
module rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx
);

  logic found;
  int   j;

  // First requester found walking upward from ptr+1 modulo NUM_REQ.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      j = (int'(ptr) + k) % NUM_REQ;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register-file write port among NUM_REQ
// writeback sources. Round-robin grant with starvation promotion and one
// registered output stage (RegWre/WriteReg/WriteData).
// Build option: REGFILE_ARB_FIXED_PRIO_EN replaces the round-robin search
// with fixed priority (lowest index wins) and removes the pointer.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_W     = REG_ADDR_W,
  parameter int DATA_W     = REG_DATA_W,
  parameter int STARVE_LIM = 4,
  parameter int CNT_W      = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  regfile_wb_arbiter_if.slave  bus,
  output logic                 RegWre,
  output logic [ADDR_W-1:0]    WriteReg,
  output logic [DATA_W-1:0]    WriteData,
  output logic                 busy,
  output logic [CNT_W-1:0]     contention_cnt
);

  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WAIT_W = $clog2(STARVE_LIM + 1);
  localparam logic [IDX_W-1:0]  PTR_RST  = IDX_W'(NUM_REQ - 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(STARVE_LIM);

  logic [NUM_REQ-1:0] valid;
  assign valid = bus.req_valid;

  // state
  logic              regwre_q, regwre_d;
  logic [ADDR_W-1:0] writereg_q, writereg_d;
  logic [DATA_W-1:0] writedata_q, writedata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WAIT_W-1:0] wait_q [NUM_REQ];
  logic [WAIT_W-1:0] wait_d [NUM_REQ];
  logic [IDX_W-1:0]  ptr;

  // grant path
  logic [NUM_REQ-1:0] rr_gnt;
  logic [IDX_W-1:0]   rr_idx;
  logic [NUM_REQ-1:0] starve_vec;
  logic [IDX_W-1:0]   starve_idx;
  logic               starve_any;
  logic [NUM_REQ-1:0] gnt_vec;
  logic [IDX_W-1:0]   gnt_idx;
  logic               gnt_en;
  logic [ADDR_W-1:0]  gnt_addr;
  logic [DATA_W-1:0]  gnt_data;
  int                 pop;

`ifdef REGFILE_ARB_FIXED_PRIO_EN
  // Searching from NUM_REQ-1 upward starts at index 0: plain fixed priority.
  assign ptr = PTR_RST;
`else
  logic [IDX_W-1:0] ptr_q, ptr_d;
  assign ptr = ptr_q;
`endif

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req (valid),
    .ptr (ptr),
    .gnt (rr_gnt),
    .idx (rr_idx)
  );

  // Lowest-index requester whose wait counter reached the limit.
  always_comb begin
    starve_vec = '0;
    starve_idx = '0;
    starve_any = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!starve_any && valid[i] && (wait_q[i] >= WAIT_MAX)) begin
        starve_any    = 1'b1;
        starve_vec[i] = 1'b1;
        starve_idx    = IDX_W'(i);
      end
    end
  end

  // Final grant: starvation overrides round-robin; nothing while in reset.
  always_comb begin
    gnt_vec = '0;
    gnt_idx = rr_idx;
    if (RST) begin
      if (starve_any) begin
        gnt_vec = starve_vec;
        gnt_idx = starve_idx;
      end else begin
        gnt_vec = rr_gnt;
      end
    end
    gnt_en   = |gnt_vec;
    gnt_addr = bus.req_addr[gnt_idx*ADDR_W +: ADDR_W];
    gnt_data = bus.req_data[gnt_idx*DATA_W +: DATA_W];
  end

  assign bus.req_ready = gnt_vec;
  assign busy          = |valid;

  // Next-state for output stage, pointer, wait counters and contention count.
  always_comb begin
    regwre_d    = 1'b0;
    writereg_d  = writereg_q;
    writedata_d = writedata_q;
    if (gnt_en) begin
      writereg_d  = gnt_addr;
      writedata_d = gnt_data;
      regwre_d    = (gnt_addr != ADDR_W'(REG_ZERO));
    end

`ifndef REGFILE_ARB_FIXED_PRIO_EN
    ptr_d = ptr_q;
    if (gnt_en) ptr_d = gnt_idx;
`endif

    for (int i = 0; i < NUM_REQ; i++) begin
      wait_d[i] = wait_q[i];
      if (!valid[i] || gnt_vec[i]) begin
        wait_d[i] = '0;
      end else if (wait_q[i] < WAIT_MAX) begin
        wait_d[i] = wait_q[i] + 1'b1;
      end
    end

    pop = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pop = pop + int'(valid[i]);
    end
    cnt_d = cnt_q;
    if ((pop > 1) && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  // Register update with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      regwre_q    <= 1'b0;
      writereg_q  <= '0;
      writedata_q <= '0;
      cnt_q       <= '0;
`ifndef REGFILE_ARB_FIXED_PRIO_EN
      ptr_q       <= PTR_RST;
`endif
      for (int i = 0; i < NUM_REQ; i++) wait_q[i] <= '0;
    end else begin
      regwre_q    <= regwre_d;
      writereg_q  <= writereg_d;
      writedata_q <= writedata_d;
      cnt_q       <= cnt_d;
`ifndef REGFILE_ARB_FIXED_PRIO_EN
      ptr_q       <= ptr_d;
`endif
      for (int i = 0; i < NUM_REQ; i++) wait_q[i] <= wait_d[i];
    end
  end

  assign RegWre         = regwre_q;
  assign WriteReg       = writereg_q;
  assign WriteData      = writedata_q;
  assign contention_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter, NUM_REQ=2, STARVE_LIM=4.
module tb_regfile_wb_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        RegWre;
  logic [4:0]  WriteReg;
  logic [31:0] WriteData;
  logic        busy;
  logic [15:0] contention_cnt;

  int passed = 0;
  int total  = 0;

  regfile_wb_arbiter_if #(.NUM_REQ(2), .ADDR_W(5), .DATA_W(32)) bus ();

  regfile_wb_arbiter #(
    .NUM_REQ(2), .ADDR_W(5), .DATA_W(32), .STARVE_LIM(4), .CNT_W(16)
  ) dut (
    .CLK            (CLK),
    .RST            (RST),
    .bus            (bus),
    .RegWre         (RegWre),
    .WriteReg       (WriteReg),
    .WriteData      (WriteData),
    .busy           (busy),
    .contention_cnt (contention_cnt)
  );

  always #5 CLK = ~CLK;

`ifdef REGFILE_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic drive(input logic [1:0] v, input logic [4:0] a0, input logic [31:0] d0,
                       input logic [4:0] a1, input logic [31:0] d1);
    bus.req_valid = v;
    bus.req_addr  = {a1, a0};
    bus.req_data  = {d1, d0};
    #1;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic we, input logic [4:0] a, input logic [31:0] d);
    chk({tag, "_we"}, 64'(RegWre), 64'(we));
    chk({tag, "_reg"}, 64'(WriteReg), 64'(a));
    chk({tag, "_data"}, 64'(WriteData), 64'(d));
  endtask

  logic [1:0] exp_rdy;

  initial begin
    // reset with both requesting
    RST = 1'b0;
    drive(2'b11, 5'd1, 32'hA1, 5'd2, 32'hB2);
    chk("rst_ready", 64'(bus.req_ready), 64'(2'b00));
    tick();
    tick();
    chk_out("rst", 1'b0, 5'd0, 32'h0);
    chk("rst_cnt", 64'(contention_cnt), 64'd0);

    // release: both valid for 4 cycles
    RST = 1'b1;
    for (int c = 0; c < 4; c++) begin
      drive(2'b11, 5'd1, 32'hA1, 5'd2, 32'hB2);
      exp_rdy = (FIXED || (c % 2 == 0)) ? 2'b01 : 2'b10;
      chk($sformatf("rot_ready%0d", c), 64'(bus.req_ready), 64'(exp_rdy));
      tick();
      if (exp_rdy == 2'b01) chk_out($sformatf("rot%0d", c), 1'b1, 5'd1, 32'hA1);
      else                  chk_out($sformatf("rot%0d", c), 1'b1, 5'd2, 32'hB2);
    end
    chk("rot_cnt", 64'(contention_cnt), 64'd4);

    // requester 0 alone, back-to-back
    drive(2'b01, 5'd3, 32'h11, 5'd0, 32'h0);
    chk("single_ready0", 64'(bus.req_ready), 64'(2'b01));
    chk("single_busy", 64'(busy), 64'd1);
    tick();
    chk_out("single0", 1'b1, 5'd3, 32'h11);
    drive(2'b01, 5'd4, 32'h22, 5'd0, 32'h0);
    chk("single_ready1", 64'(bus.req_ready), 64'(2'b01));
    tick();
    chk_out("single1", 1'b1, 5'd4, 32'h22);

    // write to $0: accepted, dropped
    drive(2'b01, 5'd0, 32'hFFFF, 5'd0, 32'h0);
    chk("zero_ready", 64'(bus.req_ready), 64'(2'b01));
    tick();
    chk_out("zero", 1'b0, 5'd0, 32'hFFFF);

    // pointer moved to 0, so requester 1 wins under round-robin
    drive(2'b11, 5'd1, 32'hA1, 5'd2, 32'hB2);
    exp_rdy = FIXED ? 2'b01 : 2'b10;
    chk("ptr_ready", 64'(bus.req_ready), 64'(exp_rdy));
    tick();
    if (FIXED) chk_out("ptr", 1'b1, 5'd1, 32'hA1);
    else       chk_out("ptr", 1'b1, 5'd2, 32'hB2);
    chk("ptr_cnt", 64'(contention_cnt), 64'd5);

    // idle: outputs hold, enable drops
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    chk("idle_ready", 64'(bus.req_ready), 64'(2'b00));
    chk("idle_busy", 64'(busy), 64'd0);
    tick();
    if (FIXED) chk_out("idle", 1'b0, 5'd1, 32'hA1);
    else       chk_out("idle", 1'b0, 5'd2, 32'hB2);

    // reset right after a grant to addr 7
    drive(2'b01, 5'd7, 32'h77, 5'd0, 32'h0);
    chk("pre_rst_ready", 64'(bus.req_ready), 64'(2'b01));
    tick();
    chk_out("pre_rst", 1'b1, 5'd7, 32'h77);
    RST = 1'b0;
    drive(2'b01, 5'd7, 32'h77, 5'd0, 32'h0);
    chk("mid_rst_ready", 64'(bus.req_ready), 64'(2'b00));
    tick();
    chk_out("mid_rst", 1'b0, 5'd0, 32'h0);
    chk("mid_rst_cnt", 64'(contention_cnt), 64'd0);
    RST = 1'b1;
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    tick();
    chk("post_rst_we", 64'(RegWre), 64'd0);

`ifdef REGFILE_ARB_FIXED_PRIO_EN
    // r0 continuous, r1 raised at t: r1 force-granted at t+4
    for (int k = 0; k < 6; k++) begin
      drive((k == 0) ? 2'b01 : 2'b11, 5'd5, 32'h55, 5'd6, 32'h66);
      if (k == 0) begin
        chk("starve_pre", 64'(bus.req_ready), 64'(2'b01));
      end else begin
        exp_rdy = (k == 5) ? 2'b10 : 2'b01;
        chk($sformatf("starve_t%0d", k - 1), 64'(bus.req_ready), 64'(exp_rdy));
      end
      tick();
    end
    chk_out("starve_out", 1'b1, 5'd6, 32'h66);
`else
    // requester 1 alone, back-to-back
    drive(2'b10, 5'd0, 32'h0, 5'd9, 32'h99);
    chk("single_r1_ready", 64'(bus.req_ready), 64'(2'b10));
    tick();
    chk_out("single_r1", 1'b1, 5'd9, 32'h99);
    drive(2'b10, 5'd0, 32'h0, 5'd9, 32'h9A);
    chk("single_r1_ready2", 64'(bus.req_ready), 64'(2'b10));
    tick();
    chk_out("single_r1b", 1'b1, 5'd9, 32'h9A);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port between NUM_REQ writeback requesters, e.g. ALU writeback, load unit and multi-cycle mul/div.
- Round-robin grant with starvation promotion.
- One registered output stage drives the register file write port: RegWre, WriteReg and WriteData.
- Sits between the writeback sources and the register file. The arbiter updates on posedge CLK and the register file samples on the following negedge.

Parameters:
- NUM_REQ, 2: number of write requesters (2..4).
- ADDR_W, 5: register address width.
- DATA_W, 32: write data width.
- STARVE_LIM, 4: wait cycles after which a pending requester is force-granted (>=1).
- CNT_W, 16: width of the contention counter.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RST  in  1  synchronous reset, active-low.
- req_valid  in  NUM_REQ  per-requester write request.
- req_addr  in  NUM_REQ*ADDR_W  packed destination register, requester i at [i*ADDR_W +: ADDR_W].
- req_data  in  NUM_REQ*DATA_W  packed write data, same packing as req_addr.
- req_ready  out  NUM_REQ  one-hot grant, combinational; the request is accepted when valid && ready.
- RegWre  out  1  registered write enable to the register file.
- WriteReg  out  ADDR_W  registered write address.
- WriteData  out  DATA_W  registered write data.
- busy  out  1  combinational OR of req_valid.
- contention_cnt  out  CNT_W  saturating count of cycles with more than one req_valid.

Behaviour:
- Reset is synchronous: on posedge CLK with RST=0:
  - RegWre=0, WriteReg=0, WriteData=0, contention_cnt=0.
  - Round-robin pointer set to NUM_REQ-1, so requester 0 wins first.
  - All wait counters cleared.
  - req_ready is forced to 0 while RST=0.
- Grant selection (combinational), evaluated each cycle:
  1. If any requester has valid=1 and wait_cnt>=STARVE_LIM, grant the lowest such index.
  2. Otherwise grant the first valid requester searching from pointer+1 upward, wrapping modulo NUM_REQ.
  3. If no requester is valid, there is no grant.
- Handshake:
  - The write port never back-pressures, so exactly one valid requester is granted every cycle that any is valid.
  - A requester holds valid, addr and data stable until it sees ready.
- Output stage, registered:
  - Latency is 1 cycle from grant to RegWre.
  - On a grant: WriteReg and WriteData take the granted requester's addr and data; RegWre=1 unless addr==0.
  - A write to $0 is accepted (ready=1) but dropped: RegWre=0.
  - With no grant: RegWre=0; WriteReg and WriteData hold their previous values.
- Pointer: updated to the granted index on every grant, including a starvation grant and a grant to address 0. Otherwise it holds.
- Wait counters, per requester:
  - +1 when valid && !ready, saturating at STARVE_LIM.
  - Cleared when granted or when valid=0.
- contention_cnt: +1 in each cycle with popcount(req_valid)>1, saturating at all-ones.
- Boundary cases:
  - Single requester: granted every cycle, back-to-back, with no bubble.
  - All requesters valid: strict rotation 0,1,..,N-1,0.
  - Same WriteReg from two requesters: serviced in grant order, and the last write wins in the register file. No coalescing.
  - Reset mid-burst: any pending output write is cancelled (RegWre=0 next cycle) and no grant is issued during reset.

Optional Feature:
- Macro: REGFILE_ARB_FIXED_PRIO_EN.
- Defined: rule 2 becomes fixed priority (lowest valid index wins), and the pointer is not instantiated. Starvation promotion (rule 1) remains, so higher indices still get serviced within STARVE_LIM+1 cycles.
- Undefined: round-robin as specified above.

Decomposition:
- Shared package regfile_pkg:
  - REG_ADDR_W=5 and REG_DATA_W=32.
  - REG_ZERO=5'd0.
  - A typedef wb_req_t {valid, addr, data} for requester-side bundling at the integration level.
- One natural sub-module, rr_pick: a pure combinational rotate, priority-encode and un-rotate. Inputs are a request vector and the pointer; outputs are a one-hot grant and its index. The fixed-priority build ties its pointer to NUM_REQ-1.

Test Plan (NUM_REQ=2, STARVE_LIM=4):
- RST=0 for 2 cycles with req_valid=2'b11 -> req_ready=00, RegWre=0, contention_cnt=0. After release, the first grant is to requester 0.
- Requester 0 only: addr=3 with data=0x11, then addr=4 with data=0x22, back-to-back -> RegWre=1 on two consecutive cycles; WriteReg=3 then 4; WriteData=0x11 then 0x22.
- Both valid for 4 cycles (r0 addr=1, r1 addr=2) -> grants 0,1,0,1; WriteReg=1,2,1,2; contention_cnt=4.
- Requester 0 with addr=0, data=0xFFFF -> req_ready[0]=1, RegWre=0 the next cycle, pointer advances to 0.
- FIXED_PRIO build: r0 held valid continuously, r1 raised at cycle t -> r1 granted at cycle t+4; r0 granted in every other cycle.
- RST=0 asserted the cycle after a grant to addr=7 -> RegWre=0 on the following edge; no write to 7 reaches the register file after the reset edge.
